spi_master_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master. Accepts a single transfer request from the register/APB side, programs and gates the SPI clock generator (`clk_div`/`clk_div_valid`/`en`), drives chip-select with setup/hold delays, and shifts TX/RX data on the generator's `spi_fall`/`spi_rise` strobes. Fixed mode 0: CPOL=0, CPHA=0, MSB first.

---
 rtl/spi_master_xfer_ctrl.sv | 152 +++++++++++++++
 tb/tb_spi_master_xfer_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer_ctrl.sv
// rtl/spi_master_xfer_ctrl.sv - SPI master transfer sequencer (mode 0, MSB first)
// Gates the clock generator, frames chip-select and shifts data on its strobes.
module spi_master_xfer_ctrl #(
  parameter int MAX_BITS = 32,
  parameter int CS_DLY   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [5:0]          len,
  input  logic [7:0]          div_cfg,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                clkgen_en,
  output logic [7:0]          clkgen_div,
  output logic                clkgen_div_valid,
  input  logic                spi_clk_i,
  input  logic                spi_rise,
  input  logic                spi_fall,
  output logic                spi_csn,
  output logic                spi_sdo,
  input  logic                spi_sdi
);

  localparam int DW = (CS_DLY < 2) ? 1 : $clog2(CS_DLY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_XFER, S_ABORT_WAIT, S_CS_HOLD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          len_q;
  logic [5:0]          bit_cnt;
  logic [DW-1:0]       dly_cnt;
  logic [MAX_BITS-1:0] tx_shift;
  logic [MAX_BITS-1:0] rx_shift;
  logic [5:0]          len_c;
  logic [5:0]          align_sh;
  logic [MAX_BITS-1:0] tx_aligned;
  logic [MAX_BITS-1:0] len_mask;
  logic                dly_done;
  logic                last_fall;

  assign len_c      = (len > 6'(MAX_BITS)) ? 6'(MAX_BITS) : len;
  assign align_sh   = 6'(MAX_BITS) - len_c;
  assign tx_aligned = tx_data << align_sh;
  assign dly_done   = (dly_cnt == DW'(CS_DLY - 1));
  assign last_fall  = spi_fall && (bit_cnt == len_q);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_BITS; i++) len_mask[i] = (6'(i) < len_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = (len_c == 6'd0) ? S_DONE : S_CS_SETUP;
      S_CS_SETUP:   if (abort) state_d = S_CS_HOLD;
                    else if (dly_done) state_d = S_XFER;
      // A final fall wins over a coincident abort: the transfer is complete.
      S_XFER:       if (last_fall) state_d = S_CS_HOLD;
                    else if (abort) state_d = (spi_fall || !spi_clk_i) ? S_CS_HOLD : S_ABORT_WAIT;
      S_ABORT_WAIT: if (spi_fall) state_d = S_CS_HOLD;
      S_CS_HOLD:    if (dly_done) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q            <= '0;
      bit_cnt          <= '0;
      dly_cnt          <= '0;
      tx_shift         <= '0;
      rx_shift         <= '0;
      rx_data          <= '0;
      aborted          <= 1'b0;
      clkgen_en        <= 1'b0;
      clkgen_div       <= '0;
      clkgen_div_valid <= 1'b0;
      spi_csn          <= 1'b1;
      spi_sdo          <= 1'b0;
    end else begin
      clkgen_div_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          len_q            <= len_c;
          clkgen_div       <= div_cfg;
          clkgen_div_valid <= 1'b1;
          tx_shift         <= tx_aligned;
          rx_shift         <= '0;
          rx_data          <= '0;
          aborted          <= 1'b0;
          bit_cnt          <= '0;
          dly_cnt          <= '0;
          if (len_c != 6'd0) begin
            spi_csn <= 1'b0;
            spi_sdo <= tx_aligned[MAX_BITS-1];
          end
        end
        S_CS_SETUP: begin
          dly_cnt <= dly_cnt + DW'(1);
          if (abort) begin
            aborted <= 1'b1;
            dly_cnt <= '0;
          end else if (dly_done) begin
            dly_cnt   <= '0;
            clkgen_en <= 1'b1;
          end
        end
        S_XFER: begin
          if (spi_rise) begin
            rx_shift <= {rx_shift[MAX_BITS-2:0], spi_sdi};
            bit_cnt  <= bit_cnt + 6'd1;
          end
          if (last_fall) begin
            clkgen_en <= 1'b0;
          end else if (abort) begin
            clkgen_en <= 1'b0;
            aborted   <= 1'b1;
          end else if (spi_fall) begin
            tx_shift <= tx_shift << 1;
            spi_sdo  <= tx_shift[MAX_BITS-2];
          end
        end
        S_CS_HOLD: begin
          dly_cnt <= dly_cnt + DW'(1);
          if (dly_done) begin
            dly_cnt <= '0;
            spi_csn <= 1'b1;
            rx_data <= rx_shift & len_mask;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// tb/tb_spi_master_xfer_ctrl.sv - table-driven bench for spi_master_xfer_ctrl
// Includes a behavioural clock generator that finishes a high phase after en drops.
module tb_spi_master_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] tx_data = '0;
  logic [5:0]  len = '0;
  logic [7:0]  div_cfg = '0;
  logic        busy, done, aborted;
  logic [31:0] rx_data;
  logic        clkgen_en, clkgen_div_valid;
  logic [7:0]  clkgen_div;
  logic        spi_csn, spi_sdo, spi_sdi;
  logic        loop_en = 1'b0;
  logic        sdi_val = 1'b0;

  logic        sck;
  logic [7:0]  cg_cnt, cg_div;
  logic        running, tick, spi_rise, spi_fall;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign spi_sdi = loop_en ? spi_sdo : sdi_val;
  assign running  = clkgen_en | sck;
  assign tick     = running && (cg_cnt == cg_div);
  assign spi_rise = tick && !sck;
  assign spi_fall = tick && sck;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck    <= 1'b0;
      cg_cnt <= '0;
      cg_div <= '0;
    end else begin
      if (clkgen_div_valid) cg_div <= clkgen_div;
      if (!running) cg_cnt <= '0;
      else if (tick) begin
        cg_cnt <= '0;
        sck    <= ~sck;
      end else cg_cnt <= cg_cnt + 8'd1;
    end
  end

  spi_master_xfer_ctrl #(.MAX_BITS(32), .CS_DLY(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .tx_data(tx_data), .len(len),
    .div_cfg(div_cfg), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .rx_data(rx_data), .clkgen_en(clkgen_en), .clkgen_div(clkgen_div),
    .clkgen_div_valid(clkgen_div_valid), .spi_clk_i(sck), .spi_rise(spi_rise),
    .spi_fall(spi_fall), .spi_csn(spi_csn), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi)
  );

  typedef struct {
    logic [5:0]  len;
    logic [31:0] tx;
    logic [7:0]  div;
    logic        lp;
    logic        sdi;
    int          kind;     // 0 none, 1 start while busy, 2 abort, 3 reset
    int          at;       // rise count after which the injection happens
    logic [31:0] exp_rx;
    logic [31:0] exp_sdo;
    int          exp_rises;
    int          exp_csn;
    logic        exp_ab;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rises = 0;
    int falls = 0;
    int csn_low = 0;
    int dones = 0;
    int done_cyc = -1;
    int stop_at = -1;
    int last_rise = 0;
    int hp_viol = 0;
    int sdo_viol = 0;
    int dd = int'(v.div) + 1;
    logic [31:0] sdo_word = '0;
    logic prev_csn = 1'b1;
    logic prev_sdo;
    logic prev_fall = 1'b0;
    logic dv1 = 1'b0;
    logic busy1 = 1'b0;
    logic [7:0] div1 = '0;
    logic injected = 1'b0;
    logic pend = 1'b0;
    logic did_reset = 1'b0;
    string p = $sformatf("v%0d_", idx);

    @(posedge clk); #1;
    loop_en = v.lp; sdi_val = v.sdi; tx_data = v.tx; len = v.len; div_cfg = v.div;
    start = 1'b1;
    prev_sdo = spi_sdo;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 1) begin dv1 = clkgen_div_valid; div1 = clkgen_div; busy1 = busy; end
      if (spi_rise) begin
        rises++;
        sdo_word = {sdo_word[30:0], spi_sdo};
        last_rise = c;
      end
      if (spi_fall) begin
        falls++;
        if (c - last_rise != dd) hp_viol++;
      end
      if (!spi_csn) csn_low++;
      if (!prev_csn && (spi_sdo != prev_sdo) && !prev_fall) sdo_viol++;
      prev_csn = spi_csn; prev_sdo = spi_sdo; prev_fall = spi_fall;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin done_cyc = c; stop_at = c + 3; end
      end
      if (v.kind != 0 && !injected && rises == v.at) begin pend = 1'b1; injected = 1'b1; end
      if (c == stop_at) break;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (v.kind == 1) begin start = 1'b1; tx_data = 32'h12; len = 6'd5; end
        else if (v.kind == 2) abort = 1'b1;
        else begin
          rstn = 1'b0;
          #1;
          chk({p, "rst_csn"}, 32'(spi_csn), 32'd1);
          chk({p, "rst_en"}, 32'(clkgen_en), 32'd0);
          chk({p, "rst_busy"}, 32'(busy), 32'd0);
          chk({p, "rst_done"}, 32'(done), 32'd0);
          chk({p, "rst_rx"}, rx_data, 32'd0);
          #1 rstn = 1'b1;
          did_reset = 1'b1;
        end
      end
      if (did_reset) break;
    end
    start = 1'b0; abort = 1'b0;
    if (did_reset) return;

    chk({p, "done_seen"}, 32'(done_cyc >= 0), 32'd1);
    chk({p, "rx"}, rx_data, v.exp_rx);
    chk({p, "rises"}, 32'(rises), 32'(v.exp_rises));
    chk({p, "falls"}, 32'(falls), 32'(v.exp_rises));
    chk({p, "sdo_seq"}, sdo_word, v.exp_sdo);
    chk({p, "csn_low"}, 32'(csn_low), 32'(v.exp_csn));
    chk({p, "done_cnt"}, 32'(dones), 32'd1);
    chk({p, "done_cyc"}, 32'(done_cyc), 32'(v.exp_csn + 1));
    chk({p, "aborted"}, 32'(aborted), 32'(v.exp_ab));
    chk({p, "div_valid"}, 32'(dv1), 32'd1);
    chk({p, "div"}, 32'(div1), 32'(v.div));
    chk({p, "busy_start"}, 32'(busy1), 32'd1);
    chk({p, "half_period"}, 32'(hp_viol), 32'd0);
    chk({p, "sdo_stable"}, 32'(sdo_viol), 32'd0);
    chk({p, "busy_end"}, 32'(busy), 32'd0);
    chk({p, "sck_end"}, 32'(sck), 32'd0);
  endtask

  initial begin
    //          len    tx            div  lp sdi kind at exp_rx        exp_sdo       rises csn ab
    vecs[0] = '{6'd8,  32'h000000A5, 8'd0, 1, 0, 0, 0, 32'h000000A5, 32'h000000A5, 8,  20,  0};
    vecs[1] = '{6'd32, 32'hDEADBEEF, 8'd3, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF, 32, 260, 0};
    vecs[2] = '{6'd0,  32'h000000FF, 8'd1, 1, 0, 0, 0, 32'h00000000, 32'h00000000, 0,  0,   0};
    vecs[3] = '{6'd8,  32'h000000FF, 8'd1, 1, 0, 2, 5, 32'h0000001F, 32'h0000001F, 5,  24,  1};
    vecs[4] = '{6'd8,  32'h000000C3, 8'd1, 1, 0, 1, 3, 32'h000000C3, 32'h000000C3, 8,  36,  0};
    vecs[5] = '{6'd4,  32'h000000F3, 8'd1, 1, 0, 0, 0, 32'h00000003, 32'h00000003, 4,  20,  0};
    vecs[6] = '{6'd1,  32'h00000001, 8'd2, 1, 0, 0, 0, 32'h00000001, 32'h00000001, 1,  10,  0};
    vecs[7] = '{6'd40, 32'h0000F00F, 8'd0, 1, 0, 0, 0, 32'h0000F00F, 32'h0000F00F, 32, 68,  0};
    vecs[8] = '{6'd8,  32'h000000A5, 8'd1, 1, 0, 3, 2, 32'h00000000, 32'h00000000, 0,  0,   0};
    vecs[9] = '{6'd8,  32'h0000005A, 8'd0, 1, 0, 0, 0, 32'h0000005A, 32'h0000005A, 8,  20,  0};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_aborted", 32'(aborted), 32'd0);
    chk("reset_rx", rx_data, 32'd0);
    chk("reset_en", 32'(clkgen_en), 32'd0);
    chk("reset_div", 32'(clkgen_div), 32'd0);
    chk("reset_div_valid", 32'(clkgen_div_valid), 32'd0);
    chk("reset_csn", 32'(spi_csn), 32'd1);
    chk("reset_sdo", 32'(spi_sdo), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
